sram_fifo_ctrl: RTL and testbench



---
 rtl/sram_fifo_pkg.sv | 12 +
 rtl/sram_fifo_obuf.sv | 29 ++
 rtl/sram_fifo_ctrl.sv | 67 ++++++
 tb/tb_sram_fifo_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: shared constants, types and pointer wrap helper for the SRAM FIFO controller
package sram_fifo_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 7;
  localparam int DEPTH = 120;
  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [ADDR_WIDTH:0] cnt_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  function automatic ptr_t wrap_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction
endpackage

// File: rtl/sram_fifo_obuf.sv
// sram_fifo_obuf: 2-entry in-order output buffer hiding the macro read latency
module sram_fifo_obuf
  import sram_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  data_t      din,
  output data_t      head,
  output logic [1:0] cnt
);
  logic [1:0] cnt_q, cnt_d;
  data_t e0_q, e0_d, e1_q, e1_d;
  // entry 0 is always the head; pops shift entry 1 forward
  always_comb begin
    e0_d = pop ? ((push && cnt_q == 2'd1) ? din : e1_q) : ((push && cnt_q == 2'd0) ? din : e0_q);
    e1_d = (push && (pop ? cnt_q == 2'd2 : cnt_q == 2'd1)) ? din : e1_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    head = e0_q;
    cnt = cnt_q;
  end
  // occupancy resets; payload registers need no reset
  always_ff @(posedge clk) begin
    cnt_q <= rst ? 2'd0 : cnt_d;
    e0_q <= e0_d;
    e1_q <= e1_d;
  end
endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: valid/ready FIFO sequencer around a 1w1r SRAM macro with a 2-entry output buffer
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  output logic  in_ready,
  input  data_t in_data,
  output logic  out_valid,
  input  logic  out_ready,
  output data_t out_data,
  output cnt_t  count,
  output logic  sram_csb0,
  output ptr_t  sram_addr0,
  output data_t sram_din0,
  output logic  sram_csb1,
  output ptr_t  sram_addr1,
  input  data_t sram_dout1
);
  ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t sram_cnt_q, sram_cnt_d;
  logic rd_inflight_q, rd_inflight_d;
  logic accept, pop, issue;
  logic [1:0] ob_cnt;
  sram_fifo_obuf u_obuf (
    .clk  (clk),
    .rst  (rst),
    .push (rd_inflight_q),
    .pop  (pop),
    .din  (sram_dout1),
    .head (out_data),
    .cnt  (ob_cnt)
  );
  // handshakes, macro port drive and next-state; reads issue only when the buffer will have room
  always_comb begin
    in_ready = !rst && sram_cnt_q < cnt_t'(DEPTH);
    accept = in_valid && in_ready;
    out_valid = ob_cnt != 2'd0;
    pop = out_valid && out_ready;
    issue = !rst && sram_cnt_q != '0 && ({1'b0, ob_cnt} + {2'b0, rd_inflight_q} - {2'b0, pop}) < 3'd2;
    sram_csb0 = !accept;
    sram_addr0 = accept ? wr_ptr_q : '0;
    sram_din0 = accept ? in_data : '0;
    sram_csb1 = !issue;
    sram_addr1 = issue ? rd_ptr_q : '0;
    wr_ptr_d = accept ? wrap_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = issue ? wrap_inc(rd_ptr_q) : rd_ptr_q;
    sram_cnt_d = sram_cnt_q + cnt_t'(accept) - cnt_t'(issue);
    rd_inflight_d = issue;
    count = sram_cnt_q + cnt_t'(rd_inflight_q) + cnt_t'(ob_cnt);
  end
  // pointer and occupancy state; a pending read is dropped on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sram_cnt_q <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sram_cnt_q <= sram_cnt_d;
      rd_inflight_q <= rd_inflight_d;
    end
  end
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: randomized scoreboard bench with a behavioural 1w1r SRAM model
module tb_sram_fifo_ctrl;
  logic clk = 0;
  logic rst = 1;
  logic in_valid = 0;
  logic in_ready;
  logic [15:0] in_data = 0;
  logic out_valid;
  logic out_ready = 0;
  logic [15:0] out_data;
  logic [7:0] count;
  logic sram_csb0, sram_csb1;
  logic [6:0] sram_addr0, sram_addr1;
  logic [15:0] sram_din0, sram_dout1;
  logic [15:0] mem [120];
  logic [15:0] q [$];
  int n_chk = 0;
  int n_fail = 0;
  bit acc_g, pop_g;

  always #5 clk = ~clk;

  sram_fifo_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count),
    .sram_csb0  (sram_csb0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1),
    .sram_dout1 (sram_dout1)
  );

  initial for (int i = 0; i < 120; i++) mem[i] = 16'hBEEF;

  always @(posedge clk) begin
    if (!sram_csb0 && sram_addr0 < 7'd120) mem[sram_addr0] <= sram_din0;
    sram_dout1 <= (!sram_csb1 && sram_addr1 < 7'd120) ? mem[sram_addr1] : 16'hDEAD;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic v, input logic [15:0] d, input logic r);
    int sz;
    in_valid = v;
    in_data = d;
    out_ready = r;
    #1;
    sz = q.size();
    acc_g = v && in_ready;
    pop_g = out_valid && r;
    n_chk++;
    if (out_valid && sz == 0) begin n_fail++; $display("FAIL valid_empty: out_valid=%0b required 0", out_valid); end
    if (pop_g) begin
      n_chk++;
      if (sz == 0 || out_data !== q[0]) begin
        n_fail++;
        $display("FAIL pop_data: got %h required %h", out_data, sz ? q[0] : 16'h0);
      end
      if (sz != 0) void'(q.pop_front());
    end
    n_chk++;
    if (sram_csb0 !== !acc_g) begin n_fail++; $display("FAIL csb0: got %b required %b", sram_csb0, !acc_g); end
    n_chk++;
    if (acc_g) begin
      if (sram_din0 !== d) begin n_fail++; $display("FAIL din0: got %h required %h", sram_din0, d); end
      q.push_back(d);
    end else if (sram_addr0 !== 7'd0 || sram_din0 !== 16'd0) begin
      n_fail++;
      $display("FAIL idle_wr_port: got addr %0d din %h required 0 0", sram_addr0, sram_din0);
    end
    if (!sram_csb0 && !sram_csb1) begin
      n_chk++;
      if (sram_addr0 == sram_addr1) begin n_fail++; $display("FAIL collision: both ports at %0d required distinct", sram_addr0); end
    end
    n_chk++;
    if (sram_addr0 >= 7'd120 || sram_addr1 >= 7'd120) begin
      n_fail++;
      $display("FAIL addr_range: got %0d/%0d required < 120", sram_addr0, sram_addr1);
    end
    n_chk++;
    if ((sz < 120 && !in_ready) || (sz >= 122 && in_ready)) begin
      n_fail++;
      $display("FAIL in_ready: got %b with %0d held", in_ready, sz);
    end
    @(negedge clk);
    n_chk++;
    if (count !== 8'(q.size())) begin n_fail++; $display("FAIL count: got %0d required %0d", count, q.size()); end
  endtask

  task automatic do_reset(input logic v);
    rst = 1;
    in_valid = v;
    out_ready = 0;
    #1;
    n_chk++;
    if (in_ready !== 1'b0 || sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ports: got in_ready %b csb0 %b csb1 %b required 0 1 1", in_ready, sram_csb0, sram_csb1);
    end
    @(negedge clk);
    rst = 0;
    in_valid = 0;
    q.delete();
    n_chk++;
    if (count !== 8'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got count %0d out_valid %b required 0 0", count, out_valid);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) step(0, 16'h0, 1);
    n_chk++;
    if (q.size() != 0 || count !== 8'd0) begin
      n_fail++;
      $display("FAIL drain: got %0d left count %0d required 0", q.size(), count);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    do_reset(1);
  endtask

  task automatic test_single();
    step(1, 16'hA5A5, 0);
    n_chk++;
    if (out_valid !== 1'b0 || count !== 8'd1) begin n_fail++; $display("FAIL single_n: got valid %b count %0d required 0 1", out_valid, count); end
    step(0, 16'h0, 0);
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_n1: got valid %b required 0", out_valid); end
    step(0, 16'h0, 0);
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 16'hA5A5) begin n_fail++; $display("FAIL single_n2: got valid %b data %h required 1 a5a5", out_valid, out_data); end
    step(0, 16'h0, 1);
    n_chk++;
    if (!pop_g || count !== 8'd0) begin n_fail++; $display("FAIL single_pop: got pop %b count %0d required 1 0", pop_g, count); end
  endtask

  task automatic test_full();
    int n_acc = 0;
    for (int i = 0; i < 130; i++) begin
      step(1, 16'($urandom), 0);
      n_acc += int'(acc_g);
    end
    n_chk++;
    if (n_acc != 122 || count !== 8'd122 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full: got acc %0d count %0d in_ready %b required 122 122 0", n_acc, count, in_ready);
    end
  endtask

  task automatic test_reset_midflight();
    int pops = 0;
    step(1, 16'($urandom), 1);
    do_reset(1);
    step(1, 16'h1234, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 16'h0, 1);
      pops += int'(pop_g);
    end
    n_chk++;
    if (pops != 1 || count !== 8'd0) begin n_fail++; $display("FAIL post_reset: got pops %0d count %0d required 1 0", pops, count); end
  endtask

  task automatic test_back_to_back();
    int misses = 0;
    for (int i = 0; i < 500; i++) begin
      step(1, 16'($urandom), 1);
      if (i >= 3 && !pop_g) misses++;
    end
    n_chk++;
    if (misses != 0) begin n_fail++; $display("FAIL throughput: got %0d idle cycles required 0", misses); end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 3) != 0, 16'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) == 0);
    for (int i = 0; i < 600; i++) step($urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 3) != 0);
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
